// File: rtl/stream_upsizer_if.sv
// rtl/stream_upsizer_if.sv - narrow-in / wide-out stream bundle for the upsizer
interface stream_upsizer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [RATIO-1:0]     out_keep;
  logic                 out_last;

  // slave: the upsizer itself; master: whoever sources beats and sinks words
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow beats into one wide word with keep/last
module stream_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  stream_upsizer_if.slave  bus
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO);
  localparam int ACC_W     = (RATIO - 1) * IN_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  generate
    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $fatal(1, "stream_upsizer: RATIO must be a power of 2 and >= 2");
    end
  endgenerate

  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic [RATIO-1:0]     out_keep_q;
  logic                 out_last_q;
  logic                 out_valid_q;

  logic                 in_ready;
  logic                 accept;
  logic                 final_beat;
  logic [ACC_W-1:0]     acc_wr;
  logic [OUT_WIDTH-1:0] acc_ext;
  logic [OUT_WIDTH-1:0] word;
  logic [RATIO-1:0]     keep;

  assign in_ready   = !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && in_ready;
  assign final_beat = (cnt == CNT_MAX) || bus.in_last;
  // top lane padded with zeros so every lane index stays in range
  assign acc_ext    = {{IN_WIDTH{1'b0}}, acc};

  always_comb begin
    acc_wr = acc;
    word   = '0;
    keep   = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (i == int'(cnt))
        acc_wr[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
    end
    for (int i = 0; i < RATIO; i++) begin
      if (i == int'(cnt))
        word[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      else if (i < int'(cnt))
        word[i*IN_WIDTH +: IN_WIDTH] = acc_ext[i*IN_WIDTH +: IN_WIDTH];
      keep[i] = (i <= int'(cnt));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      acc        <= '0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else if (accept) begin
      if (final_beat) begin
        out_data_q <= word;
        out_keep_q <= keep;
        out_last_q <= bus.in_last;
        cnt        <= '0;
        acc        <= '0;
      end else begin
        acc <= acc_wr;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // a final-beat accept in the same cycle as a drain keeps out_valid high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      out_valid_q <= 1'b0;
    else if (accept && final_beat)
      out_valid_q <= 1'b1;
    else if (bus.out_ready)
      out_valid_q <= 1'b0;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - scoreboard bench for stream_upsizer (IN_WIDTH=8, RATIO=4)
module tb_stream_upsizer;
  logic clk = 1'b0;
  logic rstn;
  logic ready_man;
  logic use_fifo;
  int   fifo_cnt;
  int   vectors = 0;
  int   miscompares = 0;

  logic [36:0] exp_q[$];
  logic        prev_rstn = 1'b0;
  logic        prev_vld  = 1'b0;
  logic        prev_rdy  = 1'b0;
  logic [36:0] prev_word = '0;

  always #5 clk = ~clk;

  stream_upsizer_if #(.IN_WIDTH(8), .RATIO(4)) bus ();

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always_comb bus.out_ready = use_fifo ? (fifo_cnt < 4) : ready_man;

  // downstream fifo of depth 4 with a randomly stalling reader
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_cnt <= 0;
    end else begin
      fifo_cnt <= fifo_cnt
                + ((use_fifo && bus.out_valid && bus.out_ready) ? 1 : 0)
                - ((fifo_cnt > 0 && $urandom_range(0, 1) == 1) ? 1 : 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] mk(input logic last, input logic [3:0] keep, input logic [31:0] data);
    return {last, keep, data};
  endfunction

  // monitor: pops at each output handshake, and checks the hold rule under backpressure
  always @(negedge clk) begin
    if (rstn && prev_rstn && prev_vld && !prev_rdy) begin
      check("hold_valid", 64'(bus.out_valid), 64'(1));
      check("hold_word", 64'({bus.out_last, bus.out_keep, bus.out_data}), 64'(prev_word));
    end
    if (rstn && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'({bus.out_last, bus.out_keep, bus.out_data}), 64'(0));
      end else begin
        check("word", 64'({bus.out_last, bus.out_keep, bus.out_data}), 64'(exp_q.pop_front()));
      end
    end
    prev_rstn <= rstn;
    prev_vld  <= bus.out_valid;
    prev_rdy  <= bus.out_ready;
    prev_word <= {bus.out_last, bus.out_keep, bus.out_data};
  end

  task automatic send_beat(input logic [7:0] d, input logic l, output int waits);
    logic took;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    waits = 0;
    for (;;) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      waits++;
      if (waits > 300) begin
        check("accept_timeout", 64'(waits), 64'(0));
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [7:0] pkt[$];
    logic [31:0] wd;
    int n;
    int len;

    rstn = 1'b0;
    ready_man = 1'b1;
    use_fifo = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_keep", 64'(bus.out_keep), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    rstn = 1'b1;
    idle(1);

    // full packet, downstream always ready
    exp_q.push_back(mk(1'b1, 4'b1111, 32'h44332211));
    send_beat(8'h11, 1'b0, w); check("stream_wait0", 64'(w), 64'(0));
    send_beat(8'h22, 1'b0, w); check("stream_wait1", 64'(w), 64'(0));
    send_beat(8'h33, 1'b0, w); check("stream_wait2", 64'(w), 64'(0));
    send_beat(8'h44, 1'b1, w); check("stream_wait3", 64'(w), 64'(0));
    check("stream_valid", 64'(bus.out_valid), 64'(1));
    check("stream_data", 64'(bus.out_data), 64'h44332211);
    check("stream_keep", 64'(bus.out_keep), 64'hf);
    check("stream_last", 64'(bus.out_last), 64'(1));
    idle(2);

    // short packet, then a single-beat packet landing in lane 0
    exp_q.push_back(mk(1'b1, 4'b0011, 32'h0000BBAA));
    exp_q.push_back(mk(1'b1, 4'b0001, 32'h000000CC));
    send_beat(8'hAA, 1'b0, w);
    send_beat(8'hBB, 1'b1, w);
    check("short_keep", 64'(bus.out_keep), 64'h3);
    check("short_data", 64'(bus.out_data), 64'h0000BBAA);
    send_beat(8'hCC, 1'b1, w);
    check("lane0_wait", 64'(w), 64'(0));
    check("lane0_keep", 64'(bus.out_keep), 64'h1);
    idle(2);

    // backpressure for 5 cycles with a beat waiting
    ready_man = 1'b0;
    exp_q.push_back(mk(1'b0, 4'b1111, 32'h44332211));
    exp_q.push_back(mk(1'b1, 4'b1111, 32'h88776655));
    send_beat(8'h11, 1'b0, w);
    send_beat(8'h22, 1'b0, w);
    send_beat(8'h33, 1'b0, w);
    send_beat(8'h44, 1'b0, w);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_data", 64'(bus.out_data), 64'h44332211);
      check("bp_keep_last", 64'({bus.out_last, bus.out_keep}), 64'h0f);
      @(posedge clk);
      #1;
    end
    ready_man = 1'b1;
    send_beat(8'h55, 1'b0, w);
    check("bp_release_wait", 64'(w), 64'(0));
    send_beat(8'h66, 1'b0, w);
    send_beat(8'h77, 1'b0, w);
    send_beat(8'h88, 1'b1, w);
    idle(2);

    // back-to-back full words without last
    exp_q.push_back(mk(1'b0, 4'b1111, 32'h04030201));
    exp_q.push_back(mk(1'b0, 4'b1111, 32'h08070605));
    for (int i = 1; i <= 8; i++) begin
      send_beat(8'(i), 1'b0, w);
      check("b2b_wait", 64'(w), 64'(0));
      if (i == 5) check("b2b_word1", 64'(bus.out_data), 64'h04030201);
    end
    check("b2b_word2", 64'(bus.out_data), 64'h08070605);
    idle(3);

    // reset mid-packet discards partial beats and clears outputs
    send_beat(8'h01, 1'b0, w);
    send_beat(8'h02, 1'b0, w);
    bus.in_valid = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_data", 64'(bus.out_data), 64'(0));
    check("mid_rst_keep_last", 64'({bus.out_last, bus.out_keep}), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
    exp_q.push_back(mk(1'b1, 4'b1111, 32'h96979899));
    send_beat(8'h99, 1'b0, w);
    send_beat(8'h98, 1'b0, w);
    send_beat(8'h97, 1'b0, w);
    send_beat(8'h96, 1'b1, w);
    check("post_rst_keep", 64'(bus.out_keep), 64'hf);
    idle(3);

    // random stress into a depth-4 fifo
    use_fifo = 1'b1;
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 9);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
      for (int g = 0; g < len; g += 4) begin
        n  = (len - g < 4) ? (len - g) : 4;
        wd = '0;
        for (int k = 0; k < n; k++) wd[k*8 +: 8] = pkt[g + k];
        exp_q.push_back(mk((g + n) == len, 4'((1 << n) - 1), wd));
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        send_beat(pkt[i], i == len - 1, w);
      end
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid/ready width upconverter: packs RATIO narrow input beats into one wide output word.
- Sits directly upstream of the team's generic fifo. Its output handshake and word map one-to-one onto the FIFO write side: w_valid, w_ready, and w_data = {out_last, out_keep, out_data}.
- Supports packet framing: a short final group is flushed early, with a lane-keep mask.

Parameters:
- IN_WIDTH, 8, width of one input beat in bits (>=1).
- RATIO, 4, input beats per output word. Must be a power of 2 and >=2; a static check fails with $fatal otherwise.
- OUT_WIDTH, IN_WIDTH*RATIO, derived output width. Localparam, not overridable.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rstn  input  1  reset. Asynchronous assert, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  IN_WIDTH  input beat payload.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  1  output word valid. Registered.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_data  output  OUT_WIDTH  packed word. Lane i = out_data[i*IN_WIDTH +: IN_WIDTH]. Registered.
- out_keep  output  RATIO  bit i set when lane i holds a real beat. Registered.
- out_last  output  1  word ends a packet. Registered.

Behaviour:
- Interface: one clock domain. Asynchronous active-low reset, rstn.
- State:
  - lane counter cnt, $clog2(RATIO) bits.
  - assembly register acc, (RATIO-1)*IN_WIDTH bits.
  - output register holding out_data/out_keep/out_last.
  - out_valid flag.
- Reset values (applied immediately on rstn low, independent of clk):
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - cnt=0, acc=0.
- Ready rule: in_ready = !out_valid || out_ready.
  - Purely combinational; does not depend on in_valid, in_data or in_last.
  - Gives zero-bubble throughput when downstream is always ready.
- Non-final beat: cnt!=RATIO-1 and !in_last.
  - Accept writes in_data into lane cnt of acc.
  - cnt increments.
  - Output register is untouched.
- Final beat: cnt==RATIO-1 or in_last.
  - Accept loads the output register:
    - lanes 0..cnt-1 from acc.
    - lane cnt = in_data.
    - lanes above cnt = 0.
    - out_keep = (1<<(cnt+1))-1.
    - out_last = in_last.
  - out_valid <= 1. cnt <= 0. acc is cleared to 0.
- Full group without in_last: out_keep=all ones, out_last=0.
- in_last on lane 0: single-lane word, out_keep=1.
- Output hold: while out_valid && !out_ready, the following stay stable:
  - out_data, out_keep, out_last.
  - in_ready=0, so no assembly progress occurs.
- Drain: out_valid && out_ready with no new final beat accepted gives out_valid <= 0 next cycle.
- Simultaneous events: drain and final-beat accept in the same cycle gives out_valid stays 1 with the new word loaded. No bubble.
- Latency: one cycle from acceptance of the final beat to out_valid high.
- Latency: zero added cycles between consecutive words.
- in_valid=0: no state change except draining.
- Reset mid-packet: partial beats in acc are discarded. A pending output word is dropped. The next accepted beat lands in lane 0.
- Protocol:
  - out_valid never drops without a handshake.
  - out_valid never depends combinationally on out_ready.
  - Checked by assertions in the bench.

Test Plan:
- Streaming, downstream ready:
  - Stimulus: RATIO=4, IN_WIDTH=8, out_ready=1. Beats 0x11,0x22,0x33,0x44 in consecutive cycles, in_last on 0x44.
  - Response: the cycle after the 4th beat, out_data=0x44332211, out_keep=4'b1111, out_last=1, in_ready constantly 1.
- Short packet:
  - Stimulus: beats 0xAA,0xBB, in_last on 0xBB.
  - Response: out_data=0x0000BBAA, out_keep=4'b0011, out_last=1. Next packet's first beat occupies lane 0.
- Backpressure:
  - Stimulus: complete word 0x44332211 (no last), then out_ready=0 for 5 cycles while in_valid=1 with 0x55.
  - Response: in_ready=0 for those 5 cycles; out_data/out_keep/out_last stable. After out_ready=1, 0x55 is accepted into lane 0.
- Back-to-back full words, out_ready=1:
  - Stimulus: 8 beats 0x01..0x08, no last.
  - Response: words 0x04030201 then 0x08070605 on consecutive final-beat+1 cycles, out_last=0, no idle cycle on input.
- Reset mid-packet:
  - Stimulus: 2 beats accepted, then rstn pulsed low asynchronously mid-cycle, then beats 0x99,0x98,0x97,0x96 with last.
  - Response: all outputs 0 during reset; next word=0x96979899, out_keep=4'b1111.
- Random stress with a fifo of DEPTH=4 downstream:
  - Stimulus: random in_valid/out_ready, random packet lengths 1..9.
  - Response: scoreboard matches every beat, lane order and keep mask; no handshake-rule assertion fires.
